// File: rtl/tiled_conv_controller.sv
// Control FSM for the convolution datapath. It loads the kernel registers,
// prefills the input window columns, then runs the sliding-window compute
// over an output-channel-tiled loop nest (for tile, for y, for x). Every load
// beat is handshaked, and the coordinate output side accepts backpressure.
// A partial last tile is loaded in full. A done pulse marks the return to
// IDLE.
module tiled_conv_controller #(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int CH_OUT_PAR         = 6,
    parameter int KERNEL_SIZE        = 3,
    parameter int K_LOAD_BEATS       = 12,
    parameter int I_LOAD_BEATS       = 4,
    parameter int CNT_W              = 32
) (
    input  logic                            clk,
    input  logic                            arst_n_in,
    input  logic                            start,
    output logic                            running,
    output logic                            done,
    input  logic                            con_valid,
    output logic                            con_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CNT_W-1:0]                output_x,
    output logic [CNT_W-1:0]                output_y,
    output logic [CNT_W-1:0]                output_ch,
    output logic [K_LOAD_BEATS-1:0]         ctrl_KDS_LE_select,
    output logic [$clog2(I_LOAD_BEATS)-1:0] ctrl_IDSS_LE_select,
    output logic                            ctrl_IDSS_shift,
    output logic                            ctrl_ODS_shift,
    output logic [1:0]                      ctrl_ODS_sel_out,
    output logic                            driving_cons
);

    localparam int KB_W  = (K_LOAD_BEATS > 1) ? $clog2(K_LOAD_BEATS) : 1;
    localparam int IB_W  = $clog2(I_LOAD_BEATS);
    localparam int SUB_W = $clog2(I_LOAD_BEATS + 2);
    localparam int GRP_W = $clog2(CH_OUT_PAR + 1);
    localparam int COL_W = 3;

    localparam logic [KB_W-1:0]         K_BEAT_LAST = KB_W'(K_LOAD_BEATS - 1);
    localparam logic [GRP_W-1:0]        K_GRP_LAST  = GRP_W'(CH_OUT_PAR - 1);
    localparam logic [IB_W-1:0]         I_BEAT_LAST = IB_W'(I_LOAD_BEATS - 1);
    localparam logic [COL_W-1:0]        COL_LAST    = COL_W'(KERNEL_SIZE - 2);
    localparam logic [SUB_W-1:0]        SUB_MAC     = SUB_W'(I_LOAD_BEATS);
    localparam logic [SUB_W-1:0]        SUB_ZERO    = SUB_W'(0);
    localparam logic [CNT_W-1:0]        X_LAST      = CNT_W'(FEATURE_MAP_WIDTH - 1);
    localparam logic [CNT_W-1:0]        Y_LAST      = CNT_W'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [CNT_W-1:0]        CH_STEP     = CNT_W'(CH_OUT_PAR);
    localparam logic [CNT_W-1:0]        CH_TOTAL    = CNT_W'(OUTPUT_NB_CHANNELS);
    localparam logic [K_LOAD_BEATS-1:0] KDS_ONE     = K_LOAD_BEATS'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_K  = 3'd1,
        ST_LOAD_I  = 3'd2,
        ST_SHIFT_I = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // ODS routing select for a compute sub-cycle: sub modulo the window width.
    function automatic logic [1:0] ods_route(input logic [SUB_W-1:0] sub);
        ods_route = 2'(int'(sub) % KERNEL_SIZE);
    endfunction

    state_t             state_r,     state_nxt_s;
    logic [KB_W-1:0]    k_beat_r,    k_beat_nxt_s;
    logic [GRP_W-1:0]   k_grp_r,     k_grp_nxt_s;
    logic [IB_W-1:0]    i_beat_r,    i_beat_nxt_s;
    logic [COL_W-1:0]   col_r,       col_nxt_s;
    logic [SUB_W-1:0]   sub_r,       sub_nxt_s;
    logic [CNT_W-1:0]   x_r,         x_nxt_s;
    logic [CNT_W-1:0]   y_r,         y_nxt_s;
    logic [CNT_W-1:0]   ch_r,        ch_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic [CNT_W-1:0]   out_x_r,     out_x_nxt_s;
    logic [CNT_W-1:0]   out_y_r,     out_y_nxt_s;
    logic [CNT_W-1:0]   out_ch_r,    out_ch_nxt_s;
    logic               done_r,      done_nxt_s;

    logic                    con_ready_s;
    logic [K_LOAD_BEATS-1:0] kds_sel_s;
    logic [IB_W-1:0]         idss_sel_s;
    logic                    idss_shift_s;
    logic                    ods_shift_s;
    logic [1:0]              ods_sel_s;
    logic                    driving_s;
    logic [CNT_W-1:0]        ch_sum_s;
    logic                    last_tile_s;

    assign ch_sum_s    = ch_r + CH_STEP;
    assign last_tile_s = (ch_sum_s >= CH_TOTAL);

    // State, loop counters and registered output fields.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_r     <= ST_IDLE;
            k_beat_r    <= '0;
            k_grp_r     <= '0;
            i_beat_r    <= '0;
            col_r       <= '0;
            sub_r       <= '0;
            x_r         <= '0;
            y_r         <= '0;
            ch_r        <= '0;
            out_valid_r <= 1'b0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            out_ch_r    <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            k_beat_r    <= k_beat_nxt_s;
            k_grp_r     <= k_grp_nxt_s;
            i_beat_r    <= i_beat_nxt_s;
            col_r       <= col_nxt_s;
            sub_r       <= sub_nxt_s;
            x_r         <= x_nxt_s;
            y_r         <= y_nxt_s;
            ch_r        <= ch_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_x_r     <= out_x_nxt_s;
            out_y_r     <= out_y_nxt_s;
            out_ch_r    <= out_ch_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    // Next-state, counter updates and datapath strobes for the current state.
    always_comb begin
        state_nxt_s  = state_r;
        k_beat_nxt_s = k_beat_r;
        k_grp_nxt_s  = k_grp_r;
        i_beat_nxt_s = i_beat_r;
        col_nxt_s    = col_r;
        sub_nxt_s    = sub_r;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        ch_nxt_s     = ch_r;
        out_x_nxt_s  = out_x_r;
        out_y_nxt_s  = out_y_r;
        out_ch_nxt_s = out_ch_r;
        done_nxt_s   = 1'b0;
        con_ready_s  = 1'b0;
        kds_sel_s    = '0;
        idss_sel_s   = '0;
        idss_shift_s = 1'b0;
        ods_shift_s  = 1'b0;
        ods_sel_s    = 2'b11;
        driving_s    = 1'b0;

        // An accepted output is retired; a commit below overrides this.
        if (out_valid_r && out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s  = ST_LOAD_K;
                    k_beat_nxt_s = '0;
                    k_grp_nxt_s  = '0;
                    ch_nxt_s     = '0;
                    x_nxt_s      = '0;
                    y_nxt_s      = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_LOAD_K: begin
                con_ready_s = 1'b1;
                kds_sel_s   = KDS_ONE << k_beat_r;
                if (con_valid) begin
                    if (k_beat_r == K_BEAT_LAST) begin
                        k_beat_nxt_s = '0;
                        if (k_grp_r == K_GRP_LAST) begin
                            k_grp_nxt_s  = '0;
                            state_nxt_s  = ST_LOAD_I;
                            x_nxt_s      = '0;
                            y_nxt_s      = '0;
                            i_beat_nxt_s = '0;
                            col_nxt_s    = '0;
                        end else begin
                            k_grp_nxt_s = k_grp_r + GRP_W'(1);
                        end
                    end else begin
                        k_beat_nxt_s = k_beat_r + KB_W'(1);
                    end
                end else begin
                    k_beat_nxt_s = k_beat_r;
                end
            end

            ST_LOAD_I: begin
                con_ready_s = 1'b1;
                idss_sel_s  = i_beat_r;
                if (con_valid) begin
                    if (i_beat_r == I_BEAT_LAST) begin
                        i_beat_nxt_s = '0;
                        state_nxt_s  = ST_SHIFT_I;
                    end else begin
                        i_beat_nxt_s = i_beat_r + IB_W'(1);
                    end
                end else begin
                    i_beat_nxt_s = i_beat_r;
                end
            end

            ST_SHIFT_I: begin
                idss_shift_s = 1'b1;
                if (col_r == COL_LAST) begin
                    col_nxt_s   = '0;
                    sub_nxt_s   = '0;
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    col_nxt_s   = col_r + COL_W'(1);
                    state_nxt_s = ST_LOAD_I;
                end
            end

            ST_COMPUTE: begin
                ods_sel_s = ods_route(sub_r);
                if (sub_r < SUB_MAC) begin
                    con_ready_s = 1'b1;
                    idss_sel_s  = IB_W'(sub_r);
                    if (con_valid) begin
                        sub_nxt_s   = sub_r + SUB_W'(1);
                        ods_shift_s = (sub_r == SUB_ZERO);
                    end else begin
                        sub_nxt_s = sub_r;
                    end
                end else if (sub_r == SUB_MAC) begin
                    driving_s = 1'b1;
                    sub_nxt_s = sub_r + SUB_W'(1);
                end else begin
                    driving_s = 1'b1;
                    if (out_valid_r && !out_ready) begin
                        // Previous coordinates not yet taken: hold the commit.
                        sub_nxt_s = sub_r;
                    end else begin
                        idss_shift_s    = 1'b1;
                        out_valid_nxt_s = 1'b1;
                        out_x_nxt_s     = x_r;
                        out_y_nxt_s     = y_r;
                        out_ch_nxt_s    = ch_r;
                        sub_nxt_s       = '0;
                        if (x_r != X_LAST) begin
                            x_nxt_s = x_r + CNT_W'(1);
                        end else if (y_r != Y_LAST) begin
                            x_nxt_s      = '0;
                            y_nxt_s      = y_r + CNT_W'(1);
                            i_beat_nxt_s = '0;
                            col_nxt_s    = '0;
                            state_nxt_s  = ST_LOAD_I;
                        end else if (!last_tile_s) begin
                            x_nxt_s      = '0;
                            y_nxt_s      = '0;
                            ch_nxt_s     = ch_sum_s;
                            k_beat_nxt_s = '0;
                            k_grp_nxt_s  = '0;
                            state_nxt_s  = ST_LOAD_K;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (!out_valid_r) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign running             = (state_r != ST_IDLE);
    assign done                = done_r;
    assign out_valid           = out_valid_r;
    assign output_x            = out_x_r;
    assign output_y            = out_y_r;
    assign output_ch           = out_ch_r;
    assign con_ready           = con_ready_s;
    assign ctrl_KDS_LE_select  = kds_sel_s;
    assign ctrl_IDSS_LE_select = idss_sel_s;
    assign ctrl_IDSS_shift     = idss_shift_s;
    assign ctrl_ODS_shift      = ods_shift_s;
    assign ctrl_ODS_sel_out    = ods_sel_s;
    assign driving_cons        = driving_s;

endmodule

// File: tb/tb_tiled_conv_controller.sv
// Self-checking bench for tiled_conv_controller: two instances (8 and 6
// output channels, 4 per tile) share all inputs. Expected outputs come from
// the loop-nest order and cycle counts derived from the layer geometry.
module tb_tiled_conv_controller;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int OC  = 8;
    localparam int OC6 = 6;
    localparam int CP  = 4;
    localparam int K   = 3;
    localparam int KB  = 12;
    localparam int IB  = 4;
    localparam int CW  = 32;

    localparam int NT        = (OC + CP - 1) / CP;
    localparam int NT6       = (OC6 + CP - 1) / CP;
    localparam int KLOAD_CYC = CP * KB;
    localparam int PRE_CYC   = (K - 1) * (IB + 1);
    localparam int SLOT_CYC  = IB + 2;
    localparam int TILE_CYC  = KLOAD_CYC + H * (PRE_CYC + W * SLOT_CYC);
    localparam int RUN_CYC   = NT * TILE_CYC + 2;
    localparam int NOUT      = NT * W * H;
    localparam int NOUT6     = NT6 * W * H;
    localparam int FIRST_LAT = KLOAD_CYC + PRE_CYC + SLOT_CYC;

    logic clk = 1'b0;
    logic arst_n_in = 1'b0;
    logic start = 1'b0;
    logic con_valid = 1'b0;
    logic out_ready = 1'b0;

    logic          running, done, con_ready, out_valid;
    logic [CW-1:0] output_x, output_y, output_ch;
    logic [KB-1:0] kds;
    logic [1:0]    idss_sel;
    logic          idss_shift, ods_shift, driving_cons;
    logic [1:0]    ods_sel;

    logic          running6, done6, con_ready6, out_valid6;
    logic [CW-1:0] output_x6, output_y6, output_ch6;
    logic [KB-1:0] kds6;
    logic [1:0]    idss_sel6;
    logic          idss_shift6, ods_shift6, driving_cons6;
    logic [1:0]    ods_sel6;

    int checks = 0;
    int errors = 0;
    int run_total = 0;
    int done_total = 0;
    int done6_total = 0;
    int hs_total = 0;
    int hs6_total = 0;
    int hs_base = 0;
    int hs6_base = 0;

    always #5 clk = ~clk;

    tiled_conv_controller #(
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(OC),
        .CH_OUT_PAR(CP), .KERNEL_SIZE(K), .K_LOAD_BEATS(KB), .I_LOAD_BEATS(IB), .CNT_W(CW)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running), .done(done),
        .con_valid(con_valid), .con_ready(con_ready), .out_valid(out_valid), .out_ready(out_ready),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
        .ctrl_KDS_LE_select(kds), .ctrl_IDSS_LE_select(idss_sel), .ctrl_IDSS_shift(idss_shift),
        .ctrl_ODS_shift(ods_shift), .ctrl_ODS_sel_out(ods_sel), .driving_cons(driving_cons)
    );

    tiled_conv_controller #(
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(OC6),
        .CH_OUT_PAR(CP), .KERNEL_SIZE(K), .K_LOAD_BEATS(KB), .I_LOAD_BEATS(IB), .CNT_W(CW)
    ) dut6 (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running6), .done(done6),
        .con_valid(con_valid), .con_ready(con_ready6), .out_valid(out_valid6), .out_ready(out_ready),
        .output_x(output_x6), .output_y(output_y6), .output_ch(output_ch6),
        .ctrl_KDS_LE_select(kds6), .ctrl_IDSS_LE_select(idss_sel6), .ctrl_IDSS_shift(idss_shift6),
        .ctrl_ODS_shift(ods_shift6), .ctrl_ODS_sel_out(ods_sel6), .driving_cons(driving_cons6)
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the n-th accepted output of a run is position n of the loop nest.
    always @(negedge clk) begin
        if (running) run_total <= run_total + 1;
        if (done) done_total <= done_total + 1;
        if (done6) done6_total <= done6_total + 1;
        if (out_valid && out_ready) begin
            check("out_x", 64'(output_x), 64'((hs_total - hs_base) % W));
            check("out_y", 64'(output_y), 64'(((hs_total - hs_base) / W) % H));
            check("out_ch", 64'(output_ch), 64'(((hs_total - hs_base) / (W * H)) * CP));
            check("out_count", 64'((hs_total - hs_base) < NOUT), 64'd1);
            hs_total <= hs_total + 1;
        end
        if (out_valid6 && out_ready) begin
            check("out6_x", 64'(output_x6), 64'((hs6_total - hs6_base) % W));
            check("out6_y", 64'(output_y6), 64'(((hs6_total - hs6_base) / W) % H));
            check("out6_ch", 64'(output_ch6), 64'(((hs6_total - hs6_base) / (W * H)) * CP));
            check("out6_count", 64'((hs6_total - hs6_base) < NOUT6), 64'd1);
            hs6_total <= hs6_total + 1;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_running"}, 64'(running), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_sel_out"}, 64'(ods_sel), 64'd3);
        check({tag, "_kds"}, 64'(kds), 64'd0);
        check({tag, "_con_ready"}, 64'(con_ready), 64'd0);
        check({tag, "_driving"}, 64'(driving_cons), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // One full layer. mode 0: nominal, 1: two 5-cycle valid drops,
    // 2: random valid/ready, 3: start pulses while running.
    task automatic run_layer(input int mode, input int exp_cyc);
        int c;
        int r0, d0, d60;
        int drop_left;
        int kind;
        bit seen_k, seen_c, got_done;
        logic [KB-1:0] exp_k;
        c = 0; drop_left = 0; kind = 0;
        seen_k = 1'b0; seen_c = 1'b0; got_done = 1'b0;
        r0 = run_total; d0 = done_total; d60 = done6_total;
        hs_base = hs_total; hs6_base = hs6_total;
        con_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!got_done && c < 5000) begin
            if (mode == 0 && c < NT * TILE_CYC && (c % TILE_CYC) < KLOAD_CYC) begin
                exp_k = 12'h001 << ((c % TILE_CYC) % KB);
                check("kds_walk", 64'(kds), 64'(exp_k));
                check("kds6_walk", 64'(kds6), 64'(exp_k));
                check("kds_ready", 64'(con_ready), 64'd1);
            end
            if (mode == 0 && c >= KLOAD_CYC && c < KLOAD_CYC + IB)
                check("prefill_sel", 64'(idss_sel), 64'(c - KLOAD_CYC));
            if (mode == 0 && c == KLOAD_CYC + IB) begin
                check("shift_i", 64'(idss_shift), 64'd1);
                check("shift_i_ready", 64'(con_ready), 64'd0);
            end
            if (mode == 0 && c == KLOAD_CYC + PRE_CYC) begin
                check("ods_shift_sub0", 64'(ods_shift), 64'd1);
                check("ods_sel_sub0", 64'(ods_sel), 64'd0);
            end
            if (mode == 0 && c == KLOAD_CYC + PRE_CYC + IB) begin
                check("mac_drive", 64'(driving_cons), 64'd1);
                check("mac_ods_sel", 64'(ods_sel), 64'(IB % K));
                check("mac_ready", 64'(con_ready), 64'd0);
            end
            if (mode == 1) begin
                if (drop_left == 0 && !seen_k && kds == 12'h080) begin
                    seen_k = 1'b1; drop_left = 5; kind = 0;
                end
                if (drop_left == 0 && seen_k && !seen_c && idss_sel == 2'd2 && ods_sel == 2'd2) begin
                    seen_c = 1'b1; drop_left = 5; kind = 1;
                end
                if (drop_left > 0) begin
                    con_valid = 1'b0;
                    drop_left--;
                    if (kind == 0) check("kds_hold", 64'(kds), 64'h080);
                    else check("sub_hold", 64'(idss_sel), 64'd2);
                end else begin
                    con_valid = 1'b1;
                end
            end
            if (mode == 2) begin
                con_valid = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end
            if (mode == 3) start = (c == 30 || c == 200 || c == 300);
            tick();
            c++;
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 64'(got_done), 64'd1);
        check("done6_same_cycle", 64'(done6), 64'(done));
        out_ready = 1'b1;
        con_valid = 1'b1;
        repeat (3) tick();
        if (mode == 1) check("drops_seen", 64'(seen_k && seen_c), 64'd1);
        if (exp_cyc > 0) check("run_len", 64'(run_total - r0), 64'(exp_cyc));
        check("done_once", 64'(done_total - d0), 64'd1);
        check("done6_once", 64'(done6_total - d60), 64'd1);
        check("n_out", 64'(hs_total - hs_base), 64'(NOUT));
        check("n_out6", 64'(hs6_total - hs6_base), 64'(NOUT6));
        check("idle_after", 64'(running), 64'd0);
    endtask

    // Backpressure: the second commit waits for the first output to be taken.
    task automatic run_backpressure();
        int c;
        int r0, d0;
        bit got_done;
        c = 0; got_done = 1'b0;
        r0 = run_total; d0 = done_total;
        hs_base = hs_total; hs6_base = hs6_total;
        con_valid = 1'b1; out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!out_valid && c < 500) begin
            tick();
            c++;
        end
        check("first_lat", 64'(c), 64'(FIRST_LAT));
        check("first_x", 64'(output_x), 64'd0);
        check("first_ch", 64'(output_ch), 64'd0);
        repeat (20) tick();
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_x", 64'(output_x), 64'd0);
        check("stall_drive", 64'(driving_cons), 64'd1);
        check("stall_ready", 64'(con_ready), 64'd0);
        check("stall_shift", 64'(idss_shift), 64'd0);
        out_ready = 1'b1;
        tick();
        check("resume_valid", 64'(out_valid), 64'd1);
        check("resume_x", 64'(output_x), 64'd1);
        check("resume_y", 64'(output_y), 64'd0);
        c = 0;
        while (!got_done && c < 2000) begin
            tick();
            c++;
            if (done) got_done = 1'b1;
        end
        check("bp_done_seen", 64'(got_done), 64'd1);
        repeat (3) tick();
        check("bp_run_len", 64'(run_total - r0), 64'(RUN_CYC + (FIRST_LAT + 20) - (FIRST_LAT + SLOT_CYC - 1)));
        check("bp_done_once", 64'(done_total - d0), 64'd1);
        check("bp_n_out", 64'(hs_total - hs_base), 64'(NOUT));
    endtask

    // Asynchronous reset in the middle of tile 1, then a clean re-run.
    task automatic run_reset_mid();
        int c;
        c = 0;
        hs_base = hs_total; hs6_base = hs6_total;
        con_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (c < TILE_CYC + KLOAD_CYC + PRE_CYC + 3 * SLOT_CYC + 2) begin
            tick();
            c++;
        end
        check("pre_rst_running", 64'(running), 64'd1);
        check("pre_rst_ch", 64'(output_ch), 64'(CP));
        arst_n_in = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_out6_valid", 64'(out_valid6), 64'd0);
        tick();
        arst_n_in = 1'b1;
        tick();
        run_layer(0, RUN_CYC);
    endtask

    initial begin
        #2;
        check_idle_outputs("reset");
        check("reset_x", 64'(output_x), 64'd0);
        check("reset_ch", 64'(output_ch), 64'd0);
        tick();
        arst_n_in = 1'b1;
        tick();
        check_idle_outputs("post_reset");
        run_layer(0, RUN_CYC);
        run_layer(1, RUN_CYC + 10);
        run_backpressure();
        run_reset_mid();
        run_layer(3, RUN_CYC);
        for (int i = 0; i < 3; i++) run_layer(2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiled_conv_controller.md
Name: tiled_conv_controller

Overview:
Parametrised next-generation control FSM for the convolution datapath. It sequences kernel loading, input-column prefill, sliding-window compute and output reporting over an output-channel-tiled loop nest. It drives the same KDS/IDSS/ODS datapath strobes as the current controller. New relative to the current controller: every load beat is handshaked, the output side has backpressure (`out_ready`), the output-channel count need not divide evenly into tiles, and a `done` pulse is produced.

Parameters:
- FEATURE_MAP_WIDTH, 1024, output positions per row (x range).
- FEATURE_MAP_HEIGHT, 1024, rows (y range).
- OUTPUT_NB_CHANNELS, 64, total output channels.
- CH_OUT_PAR, 6, output channels computed in parallel (one tile).
- KERNEL_SIZE, 3, window width; legal range 2..4.
- K_LOAD_BEATS, 12, kernel beats per output channel; width of the one-hot KDS select.
- I_LOAD_BEATS, 4, input beats per window column.
- CNT_W, 32, width of the x/y/ch counters and outputs.

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous active-low reset
- start  in  1  begin a full layer; sampled in IDLE only
- running  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse on return to IDLE
- con_valid  in  1  input stream beat valid
- con_ready  out  1  controller accepts a beat this cycle
- out_valid  out  1  output coordinates valid; held until accepted
- out_ready  in  1  consumer accepts the output
- output_x  out  CNT_W  x of the reported position
- output_y  out  CNT_W  y of the reported position
- output_ch  out  CNT_W  first channel of the reported tile
- ctrl_KDS_LE_select  out  K_LOAD_BEATS  one-hot kernel register load enable
- ctrl_IDSS_LE_select  out  $clog2(I_LOAD_BEATS)  input beat slot
- ctrl_IDSS_shift  out  1  shift the input window by one column
- ctrl_ODS_shift  out  1  shift the output data store
- ctrl_ODS_sel_out  out  2  ODS routing select; 2'b11 when idle
- driving_cons  out  1  MAC result drives the output store

Behaviour:
- Reset (asynchronous, any time including mid-layer):
  - State goes to IDLE; all counters go to 0.
  - All outputs are 0 except ctrl_ODS_sel_out, which is 2'b11.
  - Any in-flight beat or output is dropped.
- Loop order:
  - for tile, for y, for x.
  - ch advances by CH_OUT_PAR per tile.
  - The last tile is the one where ch + CH_OUT_PAR >= OUTPUT_NB_CHANNELS; the partial last tile is still fully loaded.
- States: IDLE, LOAD_K, LOAD_I, SHIFT_I, COMPUTE, DONE.
- IDLE:
  - start = 1 -> LOAD_K, with k_beat = 0, k_grp = 0, ch = 0.
  - start is ignored in every other state.
- LOAD_K:
  - con_ready = 1; ctrl_KDS_LE_select = 1 << k_beat.
  - A beat counts only on con_valid & con_ready; a missing valid holds all counters.
  - After K_LOAD_BEATS beats, k_grp increments.
  - After CH_OUT_PAR groups -> LOAD_I, with y = 0, x = 0.
- LOAD_I (row prefill):
  - con_ready = 1; ctrl_IDSS_LE_select = i_beat; beats are handshaked.
  - After I_LOAD_BEATS beats -> SHIFT_I.
- SHIFT_I:
  - 1 cycle, con_ready = 0, ctrl_IDSS_shift = 1.
  - Repeats LOAD_I/SHIFT_I until KERNEL_SIZE-1 columns are loaded, then -> COMPUTE with sub = 0.
- COMPUTE (one slot per x; sub runs 0..I_LOAD_BEATS+1):
  - ctrl_ODS_sel_out = sub mod KERNEL_SIZE in every sub-cycle.
  - sub < I_LOAD_BEATS: con_ready = 1, ctrl_IDSS_LE_select = sub; sub advances only on handshake. ctrl_ODS_shift = 1 only while sub = 0 and the handshake occurs.
  - sub = I_LOAD_BEATS (MAC cycle): driving_cons = 1.
  - sub = I_LOAD_BEATS+1 (commit cycle): driving_cons = 1, ctrl_IDSS_shift = 1.
- Commit cycle rules:
  - If out_valid = 1 and out_ready = 0, the commit stalls. sub holds and the IDSS/ODS strobes and con_ready are forced to 0 that cycle, but driving_cons stays 1.
  - Otherwise the commit registers output_x/y/ch from the current x/y/ch and sets out_valid = 1 on the next cycle.
  - After a commit: if x is not last, x+1 and stay in COMPUTE. If x is last but y is not, x = 0, y+1 -> LOAD_I. If only the tile is not last, x = y = 0, ch += CH_OUT_PAR -> LOAD_K. Otherwise -> DONE.
- out_valid:
  - Cleared on out_valid & out_ready unless a commit sets it in the same cycle; set wins.
  - output_x/y/ch are stable while out_valid = 1.
- DONE:
  - con_ready = 0; waits until out_valid = 0.
  - Then -> IDLE with done = 1 for exactly that one cycle.
- Latency: a position's coordinates appear 1 cycle after its commit cycle.
- Unused strobes are 0 in every state.

Test Plan:
Bench parameters: W=4, H=2, OC=8, CH_OUT_PAR=4, K=3, K_LOAD_BEATS=12, I_LOAD_BEATS=4.
1. con_valid and out_ready tied high, start pulse:
   - 48 LOAD_K cycles with KDS select walking 12'h001..12'h800, 4 times.
   - Then 2x(4 LOAD_I + 1 SHIFT_I) cycles, then 6-cycle COMPUTE slots.
   - out_valid reports (x,y,ch) in order (0,0,0)..(3,1,0), then (0,0,4)..(3,1,4); 16 outputs total; done pulses once.
2. Drop con_valid for 5 cycles at LOAD_K beat 7 and again at COMPUTE sub = 2:
   - Select and sub freeze; total run length grows by exactly 10 cycles; output sequence is unchanged.
3. Hold out_ready = 0 after the first output:
   - The second commit stalls; con_ready = 0 and driving_cons = 1 persist.
   - output_x stays 0 until out_ready = 1; then (1,0,0) appears the next cycle with no output lost.
4. OC = 6, CH_OUT_PAR = 4:
   - Two tiles with ch = 0 and 4; LOAD_K runs 48 beats for both tiles; done follows (3,1,4).
5. Pulse arst_n_in low mid-COMPUTE of tile 1:
   - Immediately running = 0, out_valid = 0, ctrl_ODS_sel_out = 2'b11.
   - A new start re-runs from ch = 0 with 48 kernel beats.
6. Assert start while running:
   - No effect; the run completes as in scenario 1.
